// File: rtl/core_pkg.sv
// Shared encodings for the RV32I-subset core: controller states, opcodes,
// ALU operation selects and datapath mux selects.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // One-hot instruction class; all-zero means the instruction is illegal.
    typedef struct packed {
        logic r;
        logic i_alu;
        logic lw;
        logic sw;
        logic br;
        logic jal;
    } instr_class_t;

    // Only the IR fields the controller actually decodes are kept here.
    typedef struct packed {
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic [6:0] opcode;
    } ir_fields_t;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational opcode/funct3 decoder: one-hot instruction class plus a
// legal flag for the multi-cycle controller.
module instr_class_dec
    import core_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    output instr_class_t cls,
    output logic         legal
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_R:    cls.r     = 1'b1;
            OP_I:    cls.i_alu = 1'b1;
            OP_LW:   cls.lw    = 1'b1;
            OP_SW:   cls.sw    = 1'b1;
            OP_BR:   cls.br    = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
            OP_JAL:  cls.jal   = 1'b1;
            default: cls       = '0;
        endcase
        legal = |cls;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with Moore outputs decoded
// from the state and the registered instruction fields.
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter bit RESET_TO_FETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal_instr,
    output logic [2:0]  state_o
);

    state_t       state;
    state_t       state_next;
    ir_fields_t   ir;
    instr_class_t cls;
    logic         legal;
    logic         fetch_done;
    logic         br_taken;
    logic         unused_instr_bits;

    assign fetch_done        = (state == ST_FETCH) && imem_ready;
    assign br_taken          = (ir.funct3 == F3_BEQ) ? zero : !zero;
    assign state_o           = state;
    // Register numbers and immediates belong to the datapath, not the controller.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    instr_class_dec u_dec (
        .opcode (ir.opcode),
        .funct3 (ir.funct3),
        .cls    (cls),
        .legal  (legal)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (fetch_done) begin
                ir <= '{funct7: instr[31:25], funct3: instr[14:12], opcode: instr[6:0]};
            end
        end
    end

    always_comb begin
        state_next    = state;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        alu_op        = ALUOP_ADD;
        alu_src       = 1'b0;
        alu_funct3    = 3'b000;
        alu_funct7    = 7'b0000000;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        illegal_instr = 1'b0;

        // ALU controls stay valid from EXEC to WB so address and result are stable.
        if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
            if (cls.r) begin
                alu_op     = ALUOP_FUNCT;
                alu_funct3 = ir.funct3;
                alu_funct7 = ir.funct7;
            end else if (cls.i_alu) begin
                alu_op     = ALUOP_FUNCT;
                alu_src    = 1'b1;
                alu_funct3 = ir.funct3;
            end else if (cls.lw || cls.sw) begin
                alu_op  = ALUOP_ADD;
                alu_src = 1'b1;
            end else if (cls.br) begin
                alu_op = ALUOP_SUB;
            end
        end

        case (state)
            ST_IDLE: begin
                if (RESET_TO_FETCH) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PC_PLUS4;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                if (cls.br) begin
                    pc_write   = br_taken;
                    pc_src     = br_taken ? PC_BRANCH : PC_PLUS4;
                    state_next = ST_FETCH;
                end else if (cls.jal) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_JAL;
                    state_next = ST_WB;
                end else if (cls.lw || cls.sw) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls.sw;
                if (dmem_ready) begin
                    state_next = cls.sw ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                wb_sel     = cls.lw ? WB_MEM : (cls.jal ? WB_PC4 : WB_ALU);
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams compared cycle by cycle against a phase-level model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        zero;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        illegal_instr;
    logic [2:0]  state_o;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .zero          (zero),
        .imem_req      (imem_req),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .alu_src       (alu_src),
        .alu_funct3    (alu_funct3),
        .alu_funct7    (alu_funct7),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
        logic [2:0] state;
    } outs_t;

    typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP} phase_e;
    typedef enum int {C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_BAD} cls_e;

    outs_t       obs;
    logic [31:0] cur_ir;
    logic [31:0] next_instr;
    int          n_cmp = 0;
    int          n_err = 0;

    assign obs = {imem_req, ir_write, pc_write, pc_src, alu_op, alu_src, alu_funct3,
                  alu_funct7, dmem_req, dmem_we, reg_write, wb_sel, illegal_instr, state_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cls_e classify(input logic [31:0] w);
        case (w[6:0])
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b1100011: return (w[14:12] <= 3'd1) ? C_BR : C_BAD;
            7'b1101111: return C_JAL;
            default:    return C_BAD;
        endcase
    endfunction

    // Expected outputs for one cycle of a phase; m clears bits the behaviour leaves open.
    function automatic void model(input phase_e ph, input logic [31:0] w, input logic rdy,
                                  input logic z, output outs_t e, output outs_t m);
        cls_e c;
        logic taken;
        c     = classify(w);
        taken = (w[14:12] == 3'b000) ? z : !z;
        e = '0;
        m = '1;
        case (ph)
            P_IDLE: e.state = 3'd0;
            P_FETCH: begin
                e.state    = 3'd1;
                e.imem_req = 1'b1;
                e.ir_write = rdy;
                e.pc_write = rdy;
            end
            P_DECODE: begin
                e.state = 3'd2;
                m.alu_op = '0; m.alu_src = 1'b0; m.f3 = '0; m.f7 = '0;
            end
            P_EXEC: begin
                e.state = 3'd3;
                case (c)
                    C_R:  begin e.alu_op = 2'b10; e.f3 = w[14:12]; e.f7 = w[31:25]; end
                    C_I:  begin e.alu_op = 2'b10; e.alu_src = 1'b1; e.f3 = w[14:12]; end
                    C_LW, C_SW: begin e.alu_op = 2'b00; e.alu_src = 1'b1; end
                    C_BR: begin
                        e.alu_op   = 2'b01;
                        e.pc_write = taken;
                        e.pc_src   = taken ? 2'b01 : 2'b00;
                    end
                    C_JAL: begin
                        e.pc_write = 1'b1;
                        e.pc_src   = 2'b10;
                        m.alu_op = '0; m.alu_src = 1'b0;
                    end
                    default: e.state = 3'd3;
                endcase
            end
            P_MEM: begin
                e.state    = 3'd4;
                e.dmem_req = 1'b1;
                e.dmem_we  = (c == C_SW);
                e.alu_src  = 1'b1;
            end
            P_WB: begin
                e.state     = 3'd5;
                e.reg_write = 1'b1;
                e.wb_sel    = (c == C_LW) ? 2'b01 : ((c == C_JAL) ? 2'b10 : 2'b00);
                m.alu_op = '0; m.alu_src = 1'b0; m.f3 = '0; m.f7 = '0;
            end
            P_TRAP: begin
                e.state   = 3'd6;
                e.illegal = 1'b1;
            end
            default: e.state = 3'd0;
        endcase
        if (!e.pc_write && ph != P_IDLE && ph != P_TRAP) m.pc_src = '0;
    endfunction

    // One clock cycle: drive at posedge+1, compare at negedge, return at posedge+1.
    task automatic step(input phase_e ph, input logic rdy, input logic z, input logic rst_v);
        outs_t e, m;
        rst_n      = rst_v;
        imem_ready = (ph == P_FETCH) ? rdy : 1'($urandom);
        dmem_ready = (ph == P_MEM)   ? rdy : 1'($urandom);
        zero       = (ph == P_EXEC)  ? z   : 1'($urandom);
        instr      = (ph == P_FETCH && rdy) ? next_instr : $urandom;
        @(negedge clk);
        model(ph, (ph == P_FETCH) ? next_instr : cur_ir, rdy, z, e, m);
        check($sformatf("%s ir=%h", ph.name(), cur_ir), 32'(obs & m), 32'(e & m));
        check("req_exclusive", 32'(imem_req & dmem_req), 32'd0);
        if (ph == P_FETCH && rdy) cur_ir = next_instr;
        @(posedge clk);
        #1;
    endtask

    task automatic trap_and_reset();
        repeat (4) step(P_TRAP, 1'b0, 1'b0, 1'b1);
        step(P_TRAP, 1'b0, 1'b0, 1'b0);
        step(P_IDLE, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_instr(input logic [31:0] w, input int iwait, input int dwait, input logic z);
        cls_e c;
        c          = classify(w);
        next_instr = w;
        repeat (iwait) step(P_FETCH, 1'b0, 1'b0, 1'b1);
        step(P_FETCH, 1'b1, 1'b0, 1'b1);
        step(P_DECODE, 1'b0, 1'b0, 1'b1);
        if (c == C_BAD) begin
            trap_and_reset();
            return;
        end
        step(P_EXEC, 1'b0, z, 1'b1);
        if (c == C_LW || c == C_SW) begin
            repeat (dwait) step(P_MEM, 1'b0, 1'b0, 1'b1);
            step(P_MEM, 1'b1, 1'b0, 1'b1);
        end
        if (c != C_BR && c != C_SW) step(P_WB, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 19);
        if (k < 4) begin
            w[6:0]   = 7'b0110011;
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (k < 7)  w[6:0] = 7'b0010011;
        else if (k < 10)     w[6:0] = 7'b0000011;
        else if (k < 12)     w[6:0] = 7'b0100011;
        else if (k < 16) begin
            w[6:0]   = 7'b1100011;
            w[14:12] = 3'($urandom_range(0, 1));
        end else if (k < 18) w[6:0] = 7'b1101111;
        else if (k == 18) begin
            w[6:0]   = 7'b1100011;
            w[14:12] = 3'($urandom_range(2, 7));
        end else begin
            while (classify(w) != C_BAD) w = $urandom;
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        instr      = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        zero       = 1'b0;
        cur_ir     = '0;
        next_instr = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        step(P_IDLE, 1'b0, 1'b0, 1'b1);

        run_instr(32'h002081B3, 0, 0, 1'b1);      // ADD x3,x1,x2
        run_instr(32'hFFF08093, 0, 0, 1'b0);      // ADDI x1,x1,-1
        run_instr(32'h40208133, 1, 0, 1'b0);      // SUB, one imem wait
        run_instr(32'h0000A183, 0, 3, 1'b0);      // LW, three dmem waits
        run_instr(32'h00208463, 0, 0, 1'b1);      // BEQ taken
        run_instr(32'h00208463, 0, 0, 1'b0);      // BEQ not taken
        run_instr(32'h00209463, 0, 0, 1'b1);      // BNE not taken
        run_instr(32'h00209463, 0, 0, 1'b0);      // BNE taken
        run_instr(32'h008000EF, 0, 0, 1'b0);      // JAL
        run_instr(32'h0020A223, 2, 2, 1'b1);      // SW with waits

        // Reset while a load is waiting in MEM.
        next_instr = 32'h0000A183;
        step(P_FETCH, 1'b1, 1'b0, 1'b1);
        step(P_DECODE, 1'b0, 1'b0, 1'b1);
        step(P_EXEC, 1'b0, 1'b0, 1'b1);
        step(P_MEM, 1'b0, 1'b0, 1'b1);
        step(P_MEM, 1'b0, 1'b0, 1'b0);
        step(P_IDLE, 1'b0, 1'b0, 1'b1);

        run_instr(32'h0000007F, 0, 0, 1'b0);      // illegal opcode -> TRAP
        run_instr(32'h002081B3, 0, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            run_instr(rand_instr(),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM driving the ALU control interface (alu_op, alu_src, alu_funct3, alu_funct7) plus PC, IR, register-file and memory enables.
- Consumes the fetched instruction and the ALU zero flag.
- Sequences FETCH/DECODE/EXEC/MEM/WB with ready handshakes to instruction and data memory.
- Sits between the memories and the datapath of the RV32I-subset core.

Parameters:
- RESET_TO_FETCH, 1, after the IDLE cycle go to FETCH (0 = stay in IDLE; test use only).

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- instr  in  32  instruction word from imem, valid when imem_ready=1
- imem_ready  in  1  imem response valid this cycle
- dmem_ready  in  1  dmem read data valid / write accepted this cycle
- zero  in  1  ALU result == 0
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch instr into IR and old PC into the datapath's old_pc register
- pc_write  out  1  PC update enable
- pc_src  out  2  00 PC+4, 01 old_pc+imm (branch), 10 old_pc+imm (jal)
- alu_op  out  2  00 add, 01 sub, 10 decode funct fields
- alu_src  out  1  1 = imm32 operand, 0 = rs2
- alu_funct3  out  3  funct3 to ALU
- alu_funct7  out  7  funct7 to ALU
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00 ALU, 01 dmem, 10 old_pc+4
- illegal_instr  out  1  sticky illegal-opcode flag
- state_o  out  3  current state, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Moore outputs decoded from state and the registered IR. IR resets to 0.
- Reset:
  - rst_n low at an edge forces state=IDLE and illegal_instr=0, including mid-instruction.
  - In IDLE every output is 0.
  - An outstanding memory request is dropped.
- IDLE -> FETCH on the next edge (if RESET_TO_FETCH=1).
- FETCH:
  - imem_req=1, held until imem_ready=1.
  - In the cycle where imem_ready=1: ir_write=1, pc_write=1, pc_src=00; then go to DECODE.
  - Otherwise stay in FETCH with no enables.
- DECODE:
  - One cycle, no enables; the register file is read.
  - Legal opcodes are 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ/BNE, 1101111 JAL.
  - Any other opcode, or a branch with funct3 not 000/001, goes to TRAP.
  - Otherwise go to EXEC.
- EXEC, by instruction type:
  - R: alu_op=10, alu_src=0, funct3/funct7 passed from IR.
  - I-ALU: alu_op=10, alu_src=1, funct3 from IR, alu_funct7 forced to 0000000 (the immediate occupies bits 31:25).
  - LW/SW: alu_op=00, alu_src=1.
  - Branch: alu_op=01, alu_src=0. taken = zero for BEQ, !zero for BNE. If taken, pc_write=1 and pc_src=01 in this cycle; then FETCH.
  - JAL: pc_write=1, pc_src=10.
  - Next state: R, I-ALU and JAL go to WB; LW and SW go to MEM.
  - In every non-R EXEC, alu_funct3/alu_funct7 are 0 unless stated above.
- MEM:
  - dmem_req=1, with dmem_we=1 for SW; held stable until dmem_ready=1.
  - On ready: SW goes to FETCH, LW goes to WB.
  - ALU control outputs hold their EXEC values throughout MEM so the address stays stable.
- WB:
  - reg_write=1 for one cycle.
  - wb_sel is 00 for R/I-ALU, 01 for LW, 10 for JAL.
  - An rd of x0 is still written; the register file ignores it.
  - Then go to FETCH.
- TRAP:
  - illegal_instr=1; all other outputs 0.
  - Stays in TRAP until reset.
- Latency with zero-wait memories:
  - Branch: 3 cycles FETCH to FETCH.
  - R, I-ALU, JAL, SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- Simultaneous events:
  - imem_ready while not in FETCH, or dmem_ready while not in MEM, is ignored.
  - The zero flag is sampled only in EXEC.
- Invariant: never more than one of imem_req/dmem_req high.

Decomposition:
- Shared package core_pkg holds:
  - state encodings;
  - opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL);
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - pc_src and wb_sel encodings.
- ALU and datapath import the same constants.
- One natural sub-module: instr_class_dec, a combinational opcode/funct3 decoder producing an instruction-class one-hot and a legal flag.

Test Plan:
- Reset mid-MEM: rst_n=0 at an edge while dmem_req=1 -> next cycle state_o=0, all outputs 0, illegal_instr=0; FETCH follows one cycle after release.
- ADD x3,x1,x2 (0x002081B3), zero-wait -> EXEC alu_op=10, funct7=0000000, funct3=000, alu_src=0; WB reg_write=1, wb_sel=00; back to FETCH 4 cycles after the first FETCH.
- ADDI with imm=-1 (0xFFF08093) -> EXEC alu_funct7=0000000, alu_src=1, alu_op=10.
- LW with dmem_ready low for 3 cycles -> MEM lasts 4 cycles with dmem_req=1, dmem_we=0 and alu_op=00 stable; WB wb_sel=01; total 8 cycles.
- BEQ (funct3=000):
  - with zero=1 -> EXEC pc_write=1, pc_src=01, then FETCH, 3 cycles total;
  - same instruction with zero=0 -> pc_write=0 in EXEC.
  - BNE (funct3=001): zero=1 -> pc_write=0 in EXEC; zero=0 -> pc_write=1, pc_src=01.
- Opcode 0x7F -> TRAP after DECODE, illegal_instr=1 held while imem_ready toggles; cleared only by rst_n=0.
